// File: rtl/fe_hit_stream_emu.sv
// fe_hit_stream_emu: front-end chip hit emulator.
// Filters a time-ordered hit stream by chip address, buffers matching hits in a
// compacting shift array and replays them on N_OUT channels when the local BX
// counter reaches their timestamp. Define FE_STAT_CNT_EN to add the saturating
// overflow/late drop counters and their ports.
module fe_hit_stream_emu #(
    parameter int N_OUT  = 3,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32,
    parameter int STUB_W = 8,
    parameter int BEND_W = 5,
    parameter int ADDR_W = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              en_i,
    input  logic [ADDR_W-1:0]                 layer_i,
    input  logic [ADDR_W-1:0]                 phi_i,
    input  logic [ADDR_W-1:0]                 z_i,
    input  logic [ADDR_W-1:0]                 fe_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [TS_W-1:0]                   in_ts_i,
    input  logic [ADDR_W-1:0]                 in_layer_i,
    input  logic [ADDR_W-1:0]                 in_phi_i,
    input  logic [ADDR_W-1:0]                 in_z_i,
    input  logic [ADDR_W-1:0]                 in_fe_i,
    input  logic [STUB_W-1:0]                 in_stub_i,
    input  logic [BEND_W-1:0]                 in_bend_i,
    output logic [TS_W-1:0]                   ts_cnt_o,
    output logic [N_OUT-1:0]                  hit_dv_o,
    output logic [N_OUT*(STUB_W+BEND_W)-1:0]  hit_data_o
`ifdef FE_STAT_CNT_EN
    ,
    output logic [15:0]                       ovf_cnt_o,
    output logic [15:0]                       late_cnt_o
`endif
);
    localparam int HIT_W = STUB_W + BEND_W;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [TS_W-1:0]          ts_q [DEPTH];
    logic [TS_W-1:0]          ts_d [DEPTH];
    logic [HIT_W-1:0]         hit_q[DEPTH];
    logic [HIT_W-1:0]         hit_d[DEPTH];
    logic [CW-1:0]            cnt_q, cnt_d, neq, nlate, npop;
    logic [TS_W-1:0]          bx_q, dt;
    logic [N_OUT-1:0]         dv_q, dv_d;
    logic [N_OUT*HIT_W-1:0]   data_q, data_d;
    logic                     push, stop;
    logic [IW-1:0]            s, wr;
    int                       src;

    assign in_ready_o = cnt_q < CW'(DEPTH);
    assign push       = in_valid_i && in_ready_o &&
                        {in_layer_i, in_phi_i, in_z_i, in_fe_i} == {layer_i, phi_i, z_i, fe_i};
    assign cnt_d      = cnt_q - npop + CW'(push);
    assign ts_cnt_o   = bx_q;
    assign hit_dv_o   = dv_q;
    assign hit_data_o = data_q;

    // Scan the head: late entries first, then on-time ones; stop at the first future entry.
    always_comb begin
        stop  = !en_i;
        neq   = '0;
        nlate = '0;
        dt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dt = bx_q - ts_q[i];
            if (stop || i >= int'(cnt_q)) stop = 1'b1;
            else if (dt == '0) neq = neq + 1'b1;
            else if (!dt[TS_W-1] && neq == '0) nlate = nlate + 1'b1;
            else stop = 1'b1;
        end
        npop = nlate + neq;
    end

    // Channel k carries the k-th on-time entry, which sits right after the late ones.
    always_comb begin
        dv_d   = '0;
        data_d = '0;
        s      = '0;
        for (int k = 0; k < N_OUT; k++) begin
            s = IW'(nlate) + IW'(k);
            if (k < int'(neq)) begin
                dv_d[k]                  = 1'b1;
                data_d[k*HIT_W +: HIT_W] = hit_q[s];
            end
        end
    end

    // Shift survivors to the head and append an accepted hit behind them.
    always_comb begin
        src = 0;
        wr  = IW'(cnt_q - npop);
        for (int j = 0; j < DEPTH; j++) begin
            src      = j + int'(npop);
            ts_d[j]  = src < DEPTH ? ts_q[src[IW-1:0]] : '0;
            hit_d[j] = src < DEPTH ? hit_q[src[IW-1:0]] : '0;
        end
        if (push) begin
            ts_d[wr]  = in_ts_i;
            hit_d[wr] = {in_stub_i, in_bend_i};
        end
    end

    // Payload storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk_i) begin
        ts_q  <= ts_d;
        hit_q <= hit_d;
    end

    // Buffer occupancy, BX counter and registered output channels.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            bx_q   <= '0;
            dv_q   <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            bx_q   <= en_i ? bx_q + 1'b1 : bx_q;
            dv_q   <= dv_d;
            data_q <= data_d;
        end
    end

`ifdef FE_STAT_CNT_EN
    logic [15:0] ovf_q, late_q;
    logic [CW-1:0] novf;

    assign novf       = neq > CW'(N_OUT) ? neq - CW'(N_OUT) : '0;
    assign ovf_cnt_o  = ovf_q;
    assign late_cnt_o = late_q;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] t;
        t = {1'b0, a} + 17'(b);
        return t[16] ? 16'hFFFF : t[15:0];
    endfunction

    // Saturating drop counters for overflowed and late hits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q  <= '0;
            late_q <= '0;
        end else begin
            ovf_q  <= sat_add(ovf_q, novf);
            late_q <= sat_add(late_q, nlate);
        end
    end
`endif
endmodule
